// File: rtl/bank_response_arbiter.sv
// bank_response_arbiter: round-robin merge of NUM_BANKS bank response queues
// onto one registered response channel. Each accepted response is stamped
// with its source bank and the global cycle count of the acceptance edge.
// Optional statistics (per-bank grant counts, stall cycles) are built only
// when RESP_ARB_STATS_EN is defined.
module bank_response_arbiter #(
  parameter  int NUM_BANKS = 4,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int ID_W      = 32,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_BANKS-1:0]        in_valid,
  output logic [NUM_BANKS-1:0]        in_ready,
  input  logic [NUM_BANKS*ADDR_W-1:0] in_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] in_data,
  input  logic [NUM_BANKS*ID_W-1:0]   in_id,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [DATA_W-1:0]           out_data,
  output logic [ID_W-1:0]             out_id,
  output logic [BANK_W-1:0]           out_bank,
  output logic [63:0]                 out_cycle,
`ifdef RESP_ARB_STATS_EN
  input  logic [BANK_W-1:0]           stat_sel,
  output logic [31:0]                 stat_grants,
  output logic [31:0]                 stat_stall_cycles,
`endif
  output logic [63:0]                 global_cycle
);

  logic                 out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [ID_W-1:0]      out_id_q, out_id_d;
  logic [BANK_W-1:0]    out_bank_q, out_bank_d;
  logic [63:0]          out_cycle_q, out_cycle_d;
  logic [63:0]          global_cycle_q, global_cycle_d;
  logic [BANK_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic                 can_accept;
  logic                 found;
  logic [BANK_W-1:0]    gnt;
  logic                 accept;

  // Output slot is free when empty or being drained this cycle.
  assign can_accept = !out_valid_q || out_ready;

  // Round-robin search: first valid bank at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      int                idx;
      logic [BANK_W-1:0] cand;
      idx  = (int'(rr_ptr_q) + k) % NUM_BANKS;
      cand = BANK_W'(idx);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  assign accept = found && can_accept;

  // Only the granted bank sees ready; nothing is ready while in reset.
  always_comb begin
    in_ready = '0;
    if (reset_n && accept) in_ready[gnt] = 1'b1;
  end

  // Next state: load on accept, clear valid on a bare drain, else hold.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_addr_d     = out_addr_q;
    out_data_d     = out_data_q;
    out_id_d       = out_id_q;
    out_bank_d     = out_bank_q;
    out_cycle_d    = out_cycle_q;
    rr_ptr_d       = rr_ptr_q;
    global_cycle_d = global_cycle_q + 64'd1;
    if (accept) begin
      out_valid_d = 1'b1;
      out_addr_d  = in_addr[gnt*ADDR_W +: ADDR_W];
      out_data_d  = in_data[gnt*DATA_W +: DATA_W];
      out_id_d    = in_id[gnt*ID_W +: ID_W];
      out_bank_d  = gnt;
      out_cycle_d = global_cycle_q;
      rr_ptr_d    = (int'(gnt) == NUM_BANKS - 1) ? '0 : gnt + BANK_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register, round-robin pointer and free-running cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_data_q     <= '0;
      out_id_q       <= '0;
      out_bank_q     <= '0;
      out_cycle_q    <= '0;
      global_cycle_q <= '0;
      rr_ptr_q       <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_data_q     <= out_data_d;
      out_id_q       <= out_id_d;
      out_bank_q     <= out_bank_d;
      out_cycle_q    <= out_cycle_d;
      global_cycle_q <= global_cycle_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_addr     = out_addr_q;
  assign out_data     = out_data_q;
  assign out_id       = out_id_q;
  assign out_bank     = out_bank_q;
  assign out_cycle    = out_cycle_q;
  assign global_cycle = global_cycle_q;

`ifdef RESP_ARB_STATS_EN
  logic [NUM_BANKS-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]                stall_cnt_q, stall_cnt_d;

  // Saturating grant-per-bank and output-stall counters.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && grant_cnt_q[gnt] != 32'hFFFF_FFFF)
      grant_cnt_d[gnt] = grant_cnt_q[gnt] + 32'd1;
    if (out_valid_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Statistics state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Selected bank readout; out-of-range selects read as zero.
  always_comb begin
    stat_grants = '0;
    if (int'(stat_sel) < NUM_BANKS) stat_grants = grant_cnt_q[stat_sel];
  end

  assign stat_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bank_response_arbiter.sv
// Bench for bank_response_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_bank_response_arbiter;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 32;
  localparam int BW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NB-1:0]     in_valid;
  logic [NB-1:0]     in_ready;
  logic [NB*AW-1:0]  in_addr;
  logic [NB*DW-1:0]  in_data;
  logic [NB*IW-1:0]  in_id;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_addr;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_id;
  logic [BW-1:0]     out_bank;
  logic [63:0]       out_cycle;
  logic [63:0]       global_cycle;
`ifdef RESP_ARB_STATS_EN
  logic [BW-1:0]     stat_sel;
  logic [31:0]       stat_grants;
  logic [31:0]       stat_stall_cycles;
`endif

  bank_response_arbiter #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_id(out_id),
    .out_bank(out_bank), .out_cycle(out_cycle),
`ifdef RESP_ARB_STATS_EN
    .stat_sel(stat_sel), .stat_grants(stat_grants), .stat_stall_cycles(stat_stall_cycles),
`endif
    .global_cycle(global_cycle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-bank stimulus values, packed onto the flattened buses by drive().
  logic [AW-1:0] a_v  [NB];
  logic [DW-1:0] d_v  [NB];
  logic [IW-1:0] id_v [NB];

  // Reference model state.
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_id;
  int            m_bank;
  logic [63:0]   m_cycle;
  int            m_rr;
  logic [63:0]   m_gc;
  int            acc_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int b = 0; b < NB; b++) begin
      in_addr[b*AW +: AW] = a_v[b];
      in_data[b*DW +: DW] = d_v[b];
      in_id[b*IW +: IW]   = id_v[b];
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_addr = '0; m_data = '0; m_id = '0;
    m_bank = 0; m_cycle = '0; m_rr = 0; m_gc = '0;
    acc_q.delete();
  endtask

  // One clock: check DUT against model, cross the edge, advance the model.
  task automatic step();
    logic          found;
    int            g;
    logic          can;
    logic [NB-1:0] er;
    #1;
    found = 1'b0; g = 0;
    for (int k = 0; k < NB; k++) begin
      int b;
      b = (m_rr + k) % NB;
      if (!found && in_valid[b]) begin found = 1'b1; g = b; end
    end
    can = !m_valid || out_ready;
    er = '0;
    if (found && can) er[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_addr", 64'(out_addr), 64'(m_addr));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("out_id", 64'(out_id), 64'(m_id));
    chk("out_bank", 64'(out_bank), 64'(m_bank));
    chk("out_cycle", out_cycle, m_cycle);
    chk("global_cycle", global_cycle, m_gc);
    @(posedge clk);
    if (found && can) begin
      m_valid = 1'b1; m_addr = a_v[g]; m_data = d_v[g]; m_id = id_v[g];
      m_bank = g; m_cycle = m_gc; m_rr = (g + 1) % NB;
      acc_q.push_back(g);
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    m_gc = m_gc + 64'd1;
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_global_cycle", global_cycle, 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = '0; out_ready = 1'b1;
    for (int b = 0; b < NB; b++) begin a_v[b] = '0; d_v[b] = '0; id_v[b] = '0; end
    drive();
`ifdef RESP_ARB_STATS_EN
    stat_sel = '0;
`endif
    model_reset();
    #2;
    in_valid = 4'hF;
    #1;
    chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
    chk("rst_hold_out_valid", 64'(out_valid), 64'd0);
    in_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after release.
    for (int i = 0; i < 10; i++) step();
    chk("idle_gc10", global_cycle, 64'd10);
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Single bank 2 response accepted at global cycle 5.
    apply_reset();
    for (int i = 0; i < 5; i++) step();
    a_v[2] = 32'h40; d_v[2] = 32'hAB; id_v[2] = 32'd7; drive();
    in_valid = 4'b0100; out_ready = 1'b1;
    step();
    in_valid = '0;
    chk("b2_valid", 64'(out_valid), 64'd1);
    chk("b2_bank", 64'(out_bank), 64'd2);
    chk("b2_id", 64'(out_id), 64'd7);
    chk("b2_data", 64'(out_data), 64'hAB);
    chk("b2_addr", 64'(out_addr), 64'h40);
    chk("b2_cycle", out_cycle, 64'd5);
    step();
    step();
    chk("b2_drained", 64'(out_valid), 64'd0);
    chk("b2_hold_id", 64'(out_id), 64'd7);

    // Fairness with all banks busy: 0,1,2,3,0 with no bubbles.
    apply_reset();
    for (int b = 0; b < NB; b++) begin
      a_v[b] = 32'h100 + b; d_v[b] = 32'hD0 + b; id_v[b] = 32'h10 + b;
    end
    drive();
    in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fair_no_gap", 64'(out_valid), 64'd1);
      chk("fair_order", 64'(out_bank), 64'((i % NB)));
    end
    chk("fair_count", 64'(acc_q.size()), 64'd5);

    // Stall with banks 0 and 3 pending; then next grant follows rr_ptr (=1) -> 3.
    in_valid = 4'b1001; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_bank", 64'(out_bank), 64'd0);
      chk("stall_id", 64'(out_id), 64'h10);
    end
    out_ready = 1'b1;
    step();
    chk("post_stall_bank", 64'(out_bank), 64'd3);
    chk("post_stall_id", 64'(out_id), 64'h13);

    // Reset while holding a response: dropped, counter and pointer restart.
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    in_valid = '0;
    apply_reset();
    chk("post_reset_gc", global_cycle, 64'd0);
    in_valid = 4'hF;
    step();
    chk("post_reset_rr0", 64'(out_bank), 64'd0);
    chk("post_reset_cycle", out_cycle, 64'd0);

    // Random traffic against the model, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin in_valid = '0; apply_reset(); end
      for (int b = 0; b < NB; b++) begin
        a_v[b] = $urandom; d_v[b] = $urandom; id_v[b] = $urandom;
      end
      drive();
      in_valid  = NB'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

`ifdef RESP_ARB_STATS_EN
    // Three bank-1 grants followed by four stall cycles.
    in_valid = '0;
    apply_reset();
    in_valid = 4'b0010; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    stat_sel = 2'd1;
    #1;
    chk("stat_grants_b1", 64'(stat_grants), 64'd3);
    chk("stat_stalls", 64'(stat_stall_cycles), 64'd4);
    stat_sel = 2'd0;
    #1;
    chk("stat_grants_b0", 64'(stat_grants), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on run time in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
